// File: rtl/program_loader_rom.sv
// Writable program store for the CPU: accepts a checked byte-stream image over
// valid/ready, writes it into a 16x8 array and serves CPU fetches combinationally.
module program_loader_rom #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [7:0]    DIN,
  input  logic          DIN_VALID,
  output logic          DIN_READY,
  input  logic [AW-1:0] AD,
  output logic [DW-1:0] Q,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERR
);

  // state   | meaning
  // S_IDLE  | after reset, CPU runs from the (cleared) array
  // S_CLEAR | wiping all words, one per cycle, CPU held
  // S_HDR   | waiting for the length byte N
  // S_DATA  | writing N data bytes from word 0 upward
  // S_CSUM  | comparing the checksum byte against the running sum
  // S_DONE  | image accepted, CPU released
  // S_ERROR | header or checksum rejected, CPU stays held
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam int CW = AW + 1;

  state_t                    state_q, state_d;
  logic [AW-1:0]             wptr_q, wptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [7:0]                sum_q, sum_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q, mem_d;
  logic                      xfer;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      mem_q   <= mem_d;
    end
  end

  assign DIN_READY = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign CPU_HOLD  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign DONE      = (state_q == S_DONE);
  assign ERR       = (state_q == S_ERROR);
  assign Q         = mem_q[AD];
  assign xfer      = DIN_VALID && DIN_READY;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) begin
          state_d = S_CLEAR;
          wptr_d  = '0;
        end
      end
      S_CLEAR: begin
        mem_d[wptr_q] = '0;
        wptr_d        = wptr_q + 1'b1;
        // The pointer doubles as the clear timer; the last word ends the wipe.
        if (wptr_q == AW'(DEPTH - 1)) begin
          state_d = S_HDR;
          wptr_d  = '0;
          sum_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if ((DIN == 8'd0) || (DIN > 8'(DEPTH))) begin
            state_d = S_ERROR;
          end else begin
            cnt_d   = DIN[CW-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_d[wptr_q] = DIN;
          sum_d         = sum_q + DIN;
          wptr_d        = wptr_q + 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (DIN == sum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
